// File: rtl/ahb_slave_arbiter_if.sv
// rtl/ahb_slave_arbiter_if.sv - AHB transfer types and the per-slave arbiter bus interface
package AHB_package;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;
endpackage

interface ahb_slave_arbiter_if #(
    parameter int MASTER_NUM = 4,
    parameter int MW         = $clog2(MASTER_NUM)
);
    logic [MASTER_NUM-1:0]                      hreq;
    AHB_package::htrans_type [MASTER_NUM-1:0]   htrans_m;
    logic                                       hready;
    logic [MASTER_NUM-1:0]                      hgrant;
    logic [MW-1:0]                              hmaster_addr;
    logic                                       hsel_slv;
    logic [MW-1:0]                              hmaster_data;
    logic                                       data_valid;

    modport slave (
        input  hreq, htrans_m, hready,
        output hgrant, hmaster_addr, hsel_slv, hmaster_data, data_valid
    );

    modport master (
        output hreq, htrans_m, hready,
        input  hgrant, hmaster_addr, hsel_slv, hmaster_data, data_valid
    );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// rtl/ahb_slave_arbiter.sv - round-robin per-slave arbiter with burst hold and beat limit
module ahb_slave_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int MAX_BEATS  = 16,
    parameter int MW         = $clog2(MASTER_NUM)
) (
    input  logic                hclk,
    input  logic                hreset_n,
    ahb_slave_arbiter_if.slave  bus
);
    localparam int              CW        = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0]   BEAT_LAST = CW'(MAX_BEATS - 1);
    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_OWNED  = 1'b1;

    logic [0:0]             state;
    logic [MASTER_NUM-1:0]  grant;
    logic [MW-1:0]          addr_idx;
    logic [MW-1:0]          last_owner;
    logic [MW-1:0]          data_idx;
    logic [CW-1:0]          beat_cnt;
    logic                   dvalid;

    logic [MASTER_NUM-1:0]  hreq;
    logic                   hready;
    AHB_package::htrans_type cur_trans;
    logic                   sel;
    logic                   beat_acc;
    logic                   others_req;
    logic                   keep;
    logic                   cnt_inc;
    logic [MW-1:0]          rr_idx;
    logic                   rr_found;

    assign hreq       = bus.hreq;
    assign hready     = bus.hready;
    assign cur_trans  = bus.htrans_m[addr_idx];
    assign sel        = (|grant) & hreq[addr_idx];
    assign beat_acc   = sel & (cur_trans != AHB_package::BUSY);
    assign others_req = |(hreq & ~grant);
    assign cnt_inc    = beat_acc & (beat_cnt != BEAT_LAST);

    assign keep = (state == ST_OWNED) & hreq[addr_idx]
                & ((cur_trans == AHB_package::SEQ) | (cur_trans == AHB_package::BUSY))
                & ~((beat_cnt == BEAT_LAST) & others_req);

    // last_owner equals the current owner while OWNED, so one search serves both
    // states and naturally visits the old owner last.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int j = 0; j < MASTER_NUM; j++) begin
            if (!rr_found && hreq[j] && (j > int'(last_owner))) begin
                rr_idx   = MW'(j);
                rr_found = 1'b1;
            end
        end
        for (int j = 0; j < MASTER_NUM; j++) begin
            if (!rr_found && hreq[j]) begin
                rr_idx   = MW'(j);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            addr_idx   <= '0;
            last_owner <= MW'(MASTER_NUM - 1);
            beat_cnt   <= '0;
            data_idx   <= '0;
            dvalid     <= 1'b0;
        end else if (hready) begin
            data_idx <= addr_idx;
            dvalid   <= sel & ((cur_trans == AHB_package::NONSEQ) | (cur_trans == AHB_package::SEQ));
            if (keep) begin
                if (cnt_inc) beat_cnt <= beat_cnt + 1'b1;
            end else if (rr_found) begin
                state      <= ST_OWNED;
                grant      <= {{(MASTER_NUM-1){1'b0}}, 1'b1} << rr_idx;
                addr_idx   <= rr_idx;
                last_owner <= rr_idx;
                // Re-granting the same owner is not a grant change, so its count carries on.
                if ((state == ST_OWNED) && (rr_idx == addr_idx)) begin
                    if (cnt_inc) beat_cnt <= beat_cnt + 1'b1;
                end else begin
                    beat_cnt <= '0;
                end
            end else begin
                state    <= ST_IDLE;
                grant    <= '0;
                beat_cnt <= '0;
            end
        end
    end

    assign bus.hgrant       = grant;
    assign bus.hmaster_addr = addr_idx;
    assign bus.hsel_slv     = sel;
    assign bus.hmaster_data = data_idx;
    assign bus.data_valid   = dvalid;
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb/tb_ahb_slave_arbiter.sv - directed bench with a behavioural arbiter model for ahb_slave_arbiter
module tb_ahb_slave_arbiter;
    localparam int NM = 4;
    localparam int MB = 4;
    localparam logic [1:0] T_I = 2'd0, T_B = 2'd1, T_N = 2'd2, T_S = 2'd3;

    logic hclk = 1'b0;
    logic hreset_n = 1'b0;
    always #5 hclk = ~hclk;

    ahb_slave_arbiter_if #(.MASTER_NUM(NM)) bus ();

    ahb_slave_arbiter #(.MASTER_NUM(NM), .MAX_BEATS(MB)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [NM-1:0] req_v;
    logic [1:0]    tr_v [NM];
    logic          rdy_v;

    int m_owner, m_addr, m_last, m_cnt, m_data;
    bit m_dv;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_addr  = 0;
        m_last  = NM - 1;
        m_cnt   = 0;
        m_data  = 0;
        m_dv    = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < NM; i++) begin
            req_v[i]        = (tr_v[i] != T_I);
            bus.htrans_m[i] = AHB_package::htrans_type'(tr_v[i]);
        end
        bus.hreq   = req_v;
        bus.hready = rdy_v;
    endtask

    task automatic set_in(input logic [1:0] t3, t2, t1, t0, input logic rdy);
        tr_v[0] = t0; tr_v[1] = t1; tr_v[2] = t2; tr_v[3] = t3;
        rdy_v = rdy;
        drive();
    endtask

    task automatic step(input logic [1:0] t3, t2, t1, t0, input logic rdy);
        #1;
        set_in(t3, t2, t1, t0, rdy);
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic do_reset();
        #1;
        hreset_n = 1'b0;
        set_in(T_I, T_I, T_I, T_I, 1'b1);
        @(posedge hclk);
        @(negedge hclk);
        chk_en = 1'b1;
        #1;
        hreset_n = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
    endtask

    // Model: owner is -1 when no grant; the winner is found by walking the ring after the last owner.
    int  o_tr;
    bit  m_sel, m_acc, m_others, m_cont;
    int  win;
    always @(negedge hreset_n) model_reset();
    always @(posedge hclk) begin
        if (!hreset_n) begin
            model_reset();
        end else if (rdy_v) begin
            o_tr     = (m_owner >= 0) ? int'(tr_v[m_owner]) : int'(T_I);
            m_sel    = (m_owner >= 0) && req_v[m_owner];
            m_acc    = m_sel && (o_tr != T_B);
            m_others = 1'b0;
            for (int j = 0; j < NM; j++)
                if (j != m_owner && req_v[j]) m_others = 1'b1;
            m_data = m_addr;
            m_dv   = m_sel && (o_tr == T_N || o_tr == T_S);
            m_cont = m_sel && (o_tr == T_S || o_tr == T_B) && !(m_cnt == MB - 1 && m_others);
            if (m_cont) begin
                if (m_acc && m_cnt < MB - 1) m_cnt++;
            end else begin
                win = -1;
                for (int k = 1; k <= NM; k++)
                    if (win < 0 && req_v[(m_last + k) % NM]) win = (m_last + k) % NM;
                if (win < 0) begin
                    m_owner = -1;
                    m_cnt   = 0;
                end else begin
                    if (win == m_owner) begin
                        if (m_acc && m_cnt < MB - 1) m_cnt++;
                    end else begin
                        m_cnt = 0;
                    end
                    m_owner = win;
                    m_last  = win;
                    m_addr  = win;
                end
            end
        end
    end

    always @(negedge hclk) begin
        if (chk_en) begin
            chk("hgrant", int'(bus.hgrant), (m_owner < 0) ? 0 : (1 << m_owner));
            chk("hmaster_addr", int'(bus.hmaster_addr), m_addr);
            chk("hsel_slv", int'(bus.hsel_slv), (m_owner >= 0 && req_v[m_owner]) ? 1 : 0);
            chk("hmaster_data", int'(bus.hmaster_data), m_data);
            chk("data_valid", int'(bus.data_valid), int'(m_dv));
        end
    end

    initial begin
        int exp_rr [5];
        exp_rr = '{1, 2, 4, 8, 1};
        for (int i = 0; i < NM; i++) tr_v[i] = T_I;
        rdy_v = 1'b1;
        drive();
        model_reset();

        do_reset();
        chk("rst_hgrant", int'(bus.hgrant), 0);
        chk("rst_addr", int'(bus.hmaster_addr), 0);
        chk("rst_dv", int'(bus.data_valid), 0);

        // single requester
        step(T_I, T_N, T_I, T_I, 1'b1);
        chk("single_grant", int'(bus.hgrant), 4'b0100);
        chk("single_addr", int'(bus.hmaster_addr), 2);
        chk("single_dv0", int'(bus.data_valid), 0);
        step(T_I, T_N, T_I, T_I, 1'b1);
        chk("single_dv1", int'(bus.data_valid), 1);
        chk("single_data", int'(bus.hmaster_data), 2);
        step(T_I, T_I, T_I, T_I, 1'b1);
        chk("single_release", int'(bus.hgrant), 0);
        chk("single_addr_hold", int'(bus.hmaster_addr), 2);

        // round-robin fairness
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(T_N, T_N, T_N, T_N, 1'b1);
            chk("rr_grant", int'(bus.hgrant), exp_rr[i]);
        end

        // burst hold by master 1 while master 3 waits
        do_reset();
        step(T_I, T_I, T_N, T_I, 1'b1);
        step(T_I, T_I, T_N, T_I, 1'b1);
        step(T_N, T_I, T_S, T_I, 1'b1);
        chk("burst_hold2", int'(bus.hgrant), 4'b0010);
        step(T_N, T_I, T_S, T_I, 1'b1);
        chk("burst_hold3", int'(bus.hgrant), 4'b0010);
        step(T_N, T_I, T_S, T_I, 1'b1);
        chk("burst_handover", int'(bus.hgrant), 4'b1000);
        chk("burst_overlap_data", int'(bus.hmaster_data), 1);
        step(T_N, T_I, T_I, T_I, 1'b1);
        chk("burst_m3_data", int'(bus.hmaster_data), 3);
        step(T_I, T_I, T_I, T_I, 1'b1);

        // wait states and BUSY on master 0
        do_reset();
        step(T_I, T_I, T_I, T_N, 1'b1);
        step(T_I, T_I, T_I, T_N, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(T_I, T_I, T_I, T_S, 1'b0);
            chk("wait_grant", int'(bus.hgrant), 4'b0001);
            chk("wait_data", int'(bus.hmaster_data), 0);
            chk("wait_dv", int'(bus.data_valid), 1);
        end
        step(T_I, T_I, T_I, T_S, 1'b1);
        step(T_I, T_I, T_I, T_B, 1'b1);
        chk("busy_dv", int'(bus.data_valid), 0);
        step(T_I, T_N, T_I, T_S, 1'b1);
        chk("busy_not_counted", int'(bus.hgrant), 4'b0001);
        step(T_I, T_N, T_I, T_S, 1'b1);
        chk("busy_limit", int'(bus.hgrant), 4'b0100);
        step(T_I, T_I, T_I, T_I, 1'b1);

        // beat limit with master 0 waiting
        do_reset();
        step(T_I, T_N, T_I, T_I, 1'b1);
        step(T_I, T_N, T_I, T_I, 1'b1);
        step(T_I, T_S, T_I, T_N, 1'b1);
        step(T_I, T_S, T_I, T_N, 1'b1);
        chk("limit_hold", int'(bus.hgrant), 4'b0100);
        step(T_I, T_S, T_I, T_N, 1'b1);
        chk("limit_cut", int'(bus.hgrant), 4'b0001);
        step(T_I, T_N, T_I, T_N, 1'b1);
        chk("limit_restart", int'(bus.hgrant), 4'b0100);
        step(T_I, T_I, T_I, T_I, 1'b1);

        // full INCR16 when nobody else waits
        do_reset();
        step(T_I, T_N, T_I, T_I, 1'b1);
        step(T_I, T_N, T_I, T_I, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step(T_I, T_S, T_I, T_I, 1'b1);
            chk("incr16_hold", int'(bus.hgrant), 4'b0100);
        end
        step(T_I, T_I, T_I, T_I, 1'b1);

        // asynchronous reset during beat 2
        do_reset();
        step(T_I, T_I, T_I, T_N, 1'b1);
        step(T_I, T_I, T_I, T_N, 1'b1);
        #1;
        set_in(T_I, T_I, T_I, T_S, 1'b1);
        #1;
        hreset_n = 1'b0;
        #1;
        chk("arst_hgrant", int'(bus.hgrant), 0);
        chk("arst_addr", int'(bus.hmaster_addr), 0);
        chk("arst_sel", int'(bus.hsel_slv), 0);
        chk("arst_data", int'(bus.hmaster_data), 0);
        chk("arst_dv", int'(bus.data_valid), 0);
        @(posedge hclk);
        @(negedge hclk);
        #1;
        hreset_n = 1'b1;
        step(T_N, T_I, T_N, T_I, 1'b1);
        chk("arst_first_grant", int'(bus.hgrant), 4'b0010);
        step(T_N, T_I, T_N, T_I, 1'b1);
        step(T_I, T_I, T_I, T_I, 1'b1);
        step(T_I, T_I, T_I, T_I, 1'b1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Per-slave arbiter for the multi-layer AHB interconnect. It sits in front of one slave port and collects that slave's `hreq` bit from every master-side address decoder. It grants the slave to one master at a time using round-robin, and holds the grant across bursts up to a beat limit. It also tracks which master owns the address phase and which owns the data phase, so the interconnect can steer the address/control and read/write data multiplexers.

## Interface
Parameters:
- `MASTER_NUM`, default 4: number of requesting masters (at least 2).
- `MAX_BEATS`, default 16: maximum consecutive accepted beats per grant while other masters are waiting.
- `MW`, default `$clog2(MASTER_NUM)`: master index width.

Ports:
- `hclk`, input, 1: the single clock.
- `hreset_n`, input, 1: asynchronous, active-low reset.
- `hreq`, input, `[MASTER_NUM-1:0]`: request bit for this slave from each master's decoder (already gated by non-IDLE `htrans`).
- `htrans_m`, input, `htrans_type [MASTER_NUM-1:0]`: `htrans` of each master (IDLE/BUSY/NONSEQ/SEQ from `AHB_package`).
- `hready`, input, 1: slave `hreadyout`; a 1 marks a transfer boundary.
- `hgrant`, output, `[MASTER_NUM-1:0]`: registered, one-hot or zero; the address-phase owner.
- `hmaster_addr`, output, `[MW-1:0]`: index of the `hgrant` owner; holds its last value when `hgrant` is 0.
- `hsel_slv`, output, 1: combinational, equals `|hgrant & hreq[hmaster_addr]`; this is the slave select.
- `hmaster_data`, output, `[MW-1:0]`: registered index of the master in the data phase.
- `data_valid`, output, 1: registered; 1 when a data phase is in progress.

## Operation
State: `IDLE` (`hgrant` = 0) or `OWNED` (exactly one `hgrant` bit set). Internal registers: `last_owner` and `beat_cnt` (width `$clog2(MAX_BEATS+1)`).

Arbitration point: any cycle with `hready` = 1. Nothing changes while `hready` = 0: grant, counters and owners are frozen.

At an arbitration point:
- **In IDLE:** if `hreq` is non-zero, grant the first requester searching from `last_owner+1` with wrap-around, then go to OWNED. Otherwise stay in IDLE.
- **In OWNED, continuing burst:** the owner keeps the grant when all of the following hold:
  - `hreq[owner]` = 1;
  - `htrans_m[owner]` is SEQ or BUSY;
  - not (`beat_cnt` = `MAX_BEATS-1` and some other `hreq` bit is set).
- **In OWNED, otherwise:** re-arbitrate round-robin starting from `owner+1`. The old owner is searched last, so it is re-granted only if no other master requests. If no master requests, go to IDLE.
- **Forced release:** a burst cut by the `MAX_BEATS` limit is an early burst termination. The old owner is stalled by the interconnect and must restart with NONSEQ.

Bookkeeping:
- `last_owner` updates to the newly granted index on every grant change.
- `beat_cnt`:
  - increments on each accepted beat (`hready` & `hsel_slv` & `htrans_m[owner]` ≠ BUSY), saturating at `MAX_BEATS-1`;
  - clears to 0 on every grant change or on entering IDLE.
- BUSY beats hold the grant but do not count toward `beat_cnt`.
- Data phase: on `hready` = 1, load `hmaster_data` ← `hmaster_addr` and `data_valid` ← (`hsel_slv` & `htrans_m[owner]` ∉ {IDLE, BUSY}).

## Timing
- Reset (asynchronous, while `hreset_n` = 0): `hgrant` = 0, `hmaster_addr` = 0, `hmaster_data` = 0, `data_valid` = 0, `beat_cnt` = 0, `last_owner` = `MASTER_NUM-1`, so master 0 is favoured first. Asserting reset mid-burst drops the grant immediately.
- Grant latency: `hreq` rises in cycle N with `hready` = 1 in IDLE → `hgrant` is set in N+1 → the address is accepted at the end of the first `hready` = 1 cycle starting at N+1 → `data_valid` = 1 in the following cycle.
- Handover: on the owner's last beat (`hready` = 1), the new `hgrant` appears in the next cycle. Its data phase overlaps the old owner's final data phase. `hmaster_data` still names the old owner during that overlap.
- Simultaneous requests: the round-robin order decides; there are no dead cycles between owners.
- `hready` = 0 on the handover cycle: the handover is deferred until `hready` = 1.

## Test plan
- Single requester: `hreq` = 4'b0100 with NONSEQ, `hready` = 1 → `hgrant` = 4'b0100 next cycle, `hmaster_addr` = 2, then `data_valid` = 1 and `hmaster_data` = 2 one cycle later.
- Round-robin fairness: all four masters request single NONSEQ transfers continuously from reset → grant order 0, 1, 2, 3, 0, each grant held for one beat.
- Burst hold: master 1 does a 4-beat INCR (NONSEQ, SEQ, SEQ, SEQ) while master 3 requests → master 1 holds the grant for 4 beats, and `hgrant` = 4'b1000 the cycle after the last beat.
- Wait states and BUSY: master 0 burst with `hready` = 0 for 3 cycles and one BUSY beat → `hgrant`, `beat_cnt` and `hmaster_data` are frozen during the wait, and the BUSY beat is not counted.
- Beat limit: `MAX_BEATS` = 4, master 2 does an INCR16 while master 0 waits → master 2 loses the grant after 4 accepted beats and master 0 is granted. If master 0 is not waiting, master 2 completes all 16 beats.
- Reset mid-burst: drop `hreset_n` during beat 2 of a burst → all outputs are 0 immediately. After release with `hreq` = 4'b1010, master 1 is granted first.
